aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_pkg.sv | 18 +
 rtl/aes_round_counter.sv | 37 +++
 rtl/aes_round_ctrl.sv | 132 +++++++++++++
 tb/tb_aes_round_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and constants for the AES round controller
// Holds the controller FSM state encoding, the AES-128 round count and the
// default width of the round-key select bus.
package aes_pkg;

  localparam int AES128_NUM_ROUNDS = 10;
  localparam int AES_KSEL_W        = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_KEY_WAIT = 3'd1,
    ST_INIT     = 3'd2,
    ST_ROUND    = 3'd3,
    ST_FINAL    = 3'd4,
    ST_DONE     = 3'd5
  } aes_state_e;

endpackage

// File: rtl/aes_round_counter.sv
// rtl/aes_round_counter.sv - loadable up/down round index counter
// Ports:
//   clk, resetn  : clock, synchronous active-low reset (count clears to 0)
//   load/load_val: load a new index (takes priority over en)
//   en, down     : step the index by one, downwards when down=1
//   term         : index value that raises the terminal-count flag
//   count        : current index
//   tc           : count == term
module aes_round_counter
  import aes_pkg::*;
#(
  parameter int W = AES_KSEL_W
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         down,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= down ? (count - W'(1)) : (count + W'(1));
    end
  end

  assign tc = (count == term);

endmodule

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - AES block round sequencer (IDLE/KEY_WAIT/INIT/ROUND/FINAL/DONE)
// Optional feature: define AES_ROUND_CTRL_DECRYPT_EN to add the decrypt input,
// which reverses the round-key order (NUM_ROUNDS down to 0).
// Ports:
//   clk, resetn    : clock, synchronous active-low reset
//   start          : begin one block (accepted only while idle)
//   abort          : drop the current block and return to idle
//   key_rdy        : round keys available from the key expander
//   decrypt        : (optional) direction, sampled together with start
//   encrypt_en     : key expander enable
//   key_sel        : round-key index
//   add_key_en     : AddRoundKey strobe
//   round_en       : SubBytes/ShiftRows strobe
//   mix_col_en     : MixColumns strobe
//   busy           : controller not idle
//   done           : one-cycle completion pulse
// All outputs are registered from the state of the previous cycle, so they
// trail the state register by one clock; done therefore appears
// NUM_ROUNDS+3 edges after the edge that samples start.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_NUM_ROUNDS,
  parameter int KSEL_W     = AES_KSEL_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic              key_rdy,
`ifdef AES_ROUND_CTRL_DECRYPT_EN
  input  logic              decrypt,
`endif
  output logic              encrypt_en,
  output logic [KSEL_W-1:0] key_sel,
  output logic              add_key_en,
  output logic              round_en,
  output logic              mix_col_en,
  output logic              busy,
  output logic              done
);

  aes_state_e        state;
  logic              dec_q;
  logic              dec_req;
  logic [KSEL_W-1:0] cnt;
  logic              cnt_tc;
  logic              cnt_load;
  logic              cnt_en;
  logic [KSEL_W-1:0] cnt_load_val;
  logic [KSEL_W-1:0] cnt_term;

`ifdef AES_ROUND_CTRL_DECRYPT_EN
  assign dec_req = decrypt;
`else
  assign dec_req = 1'b0;
`endif

  // The index is preloaded throughout KEY_WAIT so it is valid on entry to
  // INIT, then steps once in INIT and once per ROUND cycle, landing on the
  // FINAL key index when ROUND exits.
  assign cnt_load     = (state == ST_KEY_WAIT);
  assign cnt_en       = (state == ST_INIT) || (state == ST_ROUND);
  assign cnt_load_val = dec_q ? KSEL_W'(NUM_ROUNDS) : '0;
  assign cnt_term     = dec_q ? KSEL_W'(1) : KSEL_W'(NUM_ROUNDS - 1);

  aes_round_counter #(
    .W(KSEL_W)
  ) u_round_counter (
    .clk     (clk),
    .resetn  (resetn),
    .load    (cnt_load),
    .load_val(cnt_load_val),
    .en      (cnt_en),
    .down    (dec_q),
    .term    (cnt_term),
    .count   (cnt),
    .tc      (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      dec_q      <= 1'b0;
      encrypt_en <= 1'b0;
      key_sel    <= '0;
      add_key_en <= 1'b0;
      round_en   <= 1'b0;
      mix_col_en <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (abort && (state != ST_IDLE)) begin
      // Outputs are cleared directly so no trailing strobe or done escapes.
      state      <= ST_IDLE;
      encrypt_en <= 1'b0;
      key_sel    <= '0;
      add_key_en <= 1'b0;
      round_en   <= 1'b0;
      mix_col_en <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // busy still reflects DONE for one cycle after returning to IDLE;
          // a start in that cycle is treated as arriving while busy.
          if (start && !busy) begin
            state <= ST_KEY_WAIT;
            dec_q <= dec_req;
          end
        end
        ST_KEY_WAIT: if (key_rdy) state <= ST_INIT;
        ST_INIT:     state <= ST_ROUND;
        ST_ROUND:    if (cnt_tc) state <= ST_FINAL;
        ST_FINAL:    state <= ST_DONE;
        ST_DONE:     state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase

      busy       <= (state != ST_IDLE);
      encrypt_en <= (state == ST_KEY_WAIT) || (state == ST_INIT) ||
                    (state == ST_ROUND) || (state == ST_FINAL);
      add_key_en <= (state == ST_INIT) || (state == ST_ROUND) || (state == ST_FINAL);
      round_en   <= (state == ST_ROUND) || (state == ST_FINAL);
      mix_col_en <= (state == ST_ROUND);
      done       <= (state == ST_DONE);
      key_sel    <= ((state == ST_INIT) || (state == ST_ROUND) || (state == ST_FINAL)) ?
                    cnt : '0;
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - scoreboard bench for aes_round_ctrl
module tb_aes_round_ctrl;

  localparam int NR = 10;
  localparam int KW = 4;

  logic          clk;
  logic          resetn;
  logic          start;
  logic          abort;
  logic          key_rdy;
  logic          decrypt;
  logic          encrypt_en;
  logic [KW-1:0] key_sel;
  logic          add_key_en;
  logic          round_en;
  logic          mix_col_en;
  logic          busy;
  logic          done;

  aes_round_ctrl #(
    .NUM_ROUNDS(NR),
    .KSEL_W    (KW)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .abort     (abort),
    .key_rdy   (key_rdy),
`ifdef AES_ROUND_CTRL_DECRYPT_EN
    .decrypt   (decrypt),
`endif
    .encrypt_en(encrypt_en),
    .key_sel   (key_sel),
    .add_key_en(add_key_en),
    .round_en  (round_en),
    .mix_col_en(mix_col_en),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int ksel;
    bit rnd;
    bit mix;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;

  int d0, bad, first, lat;
  bit found;

  function automatic void check(input bit ok, input string name, input int act, input int expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endfunction

  // Reference: a block is NR+1 key steps followed by one done pulse.
  // Step s uses key s (encrypt) or NR-s (decrypt); the S-box/ShiftRows
  // strobe is off only in the first step, MixColumns only in the middle ones.
  task automatic push_op(input bit dec);
    exp_t e;
    for (int s = 0; s <= NR; s++) begin
      e.is_done = 1'b0;
      e.ksel    = dec ? (NR - s) : s;
      e.rnd     = (s > 0);
      e.mix     = (s > 0) && (s < NR);
      exp_q.push_back(e);
    end
    e.is_done = 1'b1;
    e.ksel    = 0;
    e.rnd     = 1'b0;
    e.mix     = 1'b0;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (resetn === 1'b1 && add_key_en === 1'b1) begin
      if (exp_q.size() == 0 || exp_q[0].is_done) begin
        check(1'b0, "unexpected_step", int'(key_sel), -1);
      end else begin
        mon_e = exp_q.pop_front();
        check(int'(key_sel) == mon_e.ksel, "key_sel", int'(key_sel), mon_e.ksel);
        check(round_en == mon_e.rnd, "round_en", int'(round_en), int'(mon_e.rnd));
        check(mix_col_en == mon_e.mix, "mix_col_en", int'(mix_col_en), int'(mon_e.mix));
        check(encrypt_en == 1'b1, "encrypt_en_step", int'(encrypt_en), 1);
      end
    end
    if (resetn === 1'b1 && done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0 || !exp_q[0].is_done) begin
        check(1'b0, "unexpected_done", exp_q.size(), 0);
      end else begin
        mon_e = exp_q.pop_front();
        check(busy == 1'b1 && add_key_en == 1'b0 && encrypt_en == 1'b0, "done_outputs",
              int'({busy, add_key_en, encrypt_en}), 4);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check({encrypt_en, key_sel, add_key_en, round_en, mix_col_en, busy, done} == '0, name,
          int'({encrypt_en, key_sel, add_key_en, round_en, mix_col_en, busy, done}), 0);
  endtask

  // One block: k = cycles key_rdy stays low after start, extra_at = key_sel
  // value at which a second start is pulsed (<=0: none), drop = release
  // key_rdy once the rounds have begun.
  task automatic do_op(input bit dec, input int k, input int extra_at, input bit drop);
    int  l;
    int  base;
    bit  pulsed;
    base    = done_cnt;
    l       = 0;
    pulsed  = 1'b0;
    decrypt = dec;
    key_rdy = (k == 0);
    start   = 1'b1;
    push_op(dec);
    tick();
    start = 1'b0;
    for (int c = 0; c < k + NR + 20; c++) begin
      if (k > 0 && c == k) key_rdy = 1'b1;
      if (drop && add_key_en) key_rdy = 1'b0;
      start = (extra_at > 0) && !pulsed && busy && (int'(key_sel) == extra_at);
      if (start) pulsed = 1'b1;
      tick();
      if (done) begin
        l = c + 1;
        break;
      end
    end
    start = 1'b0;
    check(l == k + NR + 3, "latency", l, k + NR + 3);
    key_rdy = 1'b1;
    repeat (3) tick();
    check(done_cnt == base + 1, "done_count", done_cnt - base, 1);
    check(busy == 1'b0, "idle_after_op", int'(busy), 0);
    check(exp_q.size() == 0, "op_drained", exp_q.size(), 0);
  endtask

  initial begin
    resetn  = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    key_rdy = 1'b0;
    decrypt = 1'b0;
    repeat (3) tick();
    check_all_zero("reset_outputs");
    resetn = 1'b1;
    tick();
    check_all_zero("idle_after_reset");

    // Basic encrypt, key already available.
    key_rdy = 1'b1;
    do_op(1'b0, 0, -1, 1'b0);

    // Long key wait.
    d0 = done_cnt;
    push_op(1'b0);
    key_rdy = 1'b0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (!(encrypt_en && busy && !add_key_en && key_sel == '0 && !done)) bad++;
    end
    check(bad == 0, "key_wait_hold", bad, 0);
    key_rdy = 1'b1;
    first = 0;
    lat   = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (add_key_en && first == 0) first = c + 1;
      if (done) begin
        lat = c + 1;
        break;
      end
    end
    check(first == 2, "init_after_key_rdy", first, 2);
    check(lat == NR + 3, "key_wait_latency", lat, NR + 3);
    repeat (3) tick();
    check(done_cnt == d0 + 1, "key_wait_done_count", done_cnt - d0, 1);

    // Abort at key_sel 5.
    d0 = done_cnt;
    push_op(1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (add_key_en && key_sel == KW'(5)) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check(found, "abort_reach_ks5", int'(found), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
    check_all_zero("abort_outputs");
    repeat (20) tick();
    check(done_cnt == d0, "no_done_after_abort", done_cnt - d0, 0);
    do_op(1'b0, 0, -1, 1'b0);

    // Second start while busy is ignored.
    do_op(1'b0, 0, 3, 1'b0);
    repeat (20) tick();
    check(exp_q.size() == 0 && !busy, "no_queued_start", exp_q.size(), 0);

    // Reset at key_sel 7.
    d0 = done_cnt;
    push_op(1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (add_key_en && key_sel == KW'(7)) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check(found, "reset_reach_ks7", int'(found), 1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    exp_q.delete();
    check_all_zero("mid_reset_outputs");
    repeat (15) tick();
    check_all_zero("idle_after_mid_reset");
    check(done_cnt == d0, "no_done_after_reset", done_cnt - d0, 0);

`ifdef AES_ROUND_CTRL_DECRYPT_EN
    do_op(1'b1, 0, -1, 1'b0);
`endif

    // Randomized blocks: key delay, key_rdy drop, stray starts, direction.
    for (int i = 0; i < 8; i++) begin
      bit dec;
`ifdef AES_ROUND_CTRL_DECRYPT_EN
      dec = 1'($urandom_range(0, 1));
`else
      dec = 1'b0;
`endif
      do_op(dec, int'($urandom_range(0, 4)),
            ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, NR - 1)) : -1,
            1'($urandom_range(0, 1)));
    end

    check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
